// File: rtl/dc_mcl_pkg.sv
// ---------------------------------------------------------------------------
// dc_mcl_pkg
// Shared types and constants for the main-control-logic frame scheduler.
//   - field widths of the frame configuration
//   - frame_state_t : scheduler FSM states
//   - CFG_ADDR_*    : shadow register map used by the host write port
//   - dc_mcl_frame_cfg_t : one complete frame configuration; the same type
//     is used for the host-writable shadow set and the frame-stable active set
// ---------------------------------------------------------------------------
package dc_mcl_pkg;

    localparam int SCR_SIZE_WIDTH     = 12;
    localparam int SCALE_METHOD_WIDTH = 2;
    localparam int RGB_WIDTH          = 24;

    typedef enum logic [2:0] {
        UNCONF  = 3'd0,
        ARM     = 3'd1,
        ISSUE   = 3'd2,
        ACTIVE  = 3'd3,
        RECOVER = 3'd4
    } frame_state_t;

    localparam logic [3:0] CFG_ADDR_OFF_X     = 4'd0;
    localparam logic [3:0] CFG_ADDR_OFF_Y     = 4'd1;
    localparam logic [3:0] CFG_ADDR_IMG_W     = 4'd2;
    localparam logic [3:0] CFG_ADDR_IMG_H     = 4'd3;
    localparam logic [3:0] CFG_ADDR_SCR_W     = 4'd4;
    localparam logic [3:0] CFG_ADDR_SCR_H     = 4'd5;
    localparam logic [3:0] CFG_ADDR_TEX_W     = 4'd6;
    localparam logic [3:0] CFG_ADDR_TEX_H     = 4'd7;
    localparam logic [3:0] CFG_ADDR_SCALE     = 4'd8;
    localparam logic [3:0] CFG_ADDR_BORDER    = 4'd9;
    localparam logic [3:0] CFG_ADDR_CLR_STICKY = 4'd15;

    typedef struct packed {
        logic [SCR_SIZE_WIDTH-1:0]     off_x;
        logic [SCR_SIZE_WIDTH-1:0]     off_y;
        logic [SCR_SIZE_WIDTH-1:0]     img_w;
        logic [SCR_SIZE_WIDTH-1:0]     img_h;
        logic [SCR_SIZE_WIDTH-1:0]     scr_w;
        logic [SCR_SIZE_WIDTH-1:0]     scr_h;
        logic [SCR_SIZE_WIDTH-1:0]     tex_w;
        logic [SCR_SIZE_WIDTH-1:0]     tex_h;
        logic [SCALE_METHOD_WIDTH-1:0] scale;
        logic [RGB_WIDTH-1:0]          border;
    } dc_mcl_frame_cfg_t;

endpackage

// File: rtl/dc_mcl_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// dc_mcl_frame_scheduler_if
// Link between the frame scheduler (master) and the lines display manager
// (slave).
//   conf_*          active frame configuration, stable for a whole frame
//   conf_valid      launch request, master -> slave
//   conf_ready      slave idle / accepting
//   frame_finished  slave one-cycle pulse at end of frame
//   underrun        slave one-cycle pulse on underrun
// Handshake: a frame launch transfers on the first rising clock edge where
// conf_valid && conf_ready are both high. Once raised, conf_valid stays high
// and conf_* stay unchanged until that transfer; the master never withdraws
// a request.
// ---------------------------------------------------------------------------
interface dc_mcl_frame_scheduler_if;
    import dc_mcl_pkg::*;

    logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_x;
    logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_y;
    logic [SCR_SIZE_WIDTH-1:0]     conf_image_width;
    logic [SCR_SIZE_WIDTH-1:0]     conf_image_height;
    logic [SCR_SIZE_WIDTH-1:0]     conf_screen_width;
    logic [SCR_SIZE_WIDTH-1:0]     conf_screen_height;
    logic [SCR_SIZE_WIDTH-1:0]     conf_tex_width;
    logic [SCR_SIZE_WIDTH-1:0]     conf_tex_height;
    logic [SCALE_METHOD_WIDTH-1:0] conf_scale_method;
    logic [RGB_WIDTH-1:0]          conf_border_color;
    logic                          conf_valid;
    logic                          conf_ready;
    logic                          frame_finished;
    logic                          underrun;

    modport master (
        output conf_image_offset_x, conf_image_offset_y,
        output conf_image_width, conf_image_height,
        output conf_screen_width, conf_screen_height,
        output conf_tex_width, conf_tex_height,
        output conf_scale_method, conf_border_color,
        output conf_valid,
        input  conf_ready, frame_finished, underrun
    );

    modport slave (
        input  conf_image_offset_x, conf_image_offset_y,
        input  conf_image_width, conf_image_height,
        input  conf_screen_width, conf_screen_height,
        input  conf_tex_width, conf_tex_height,
        input  conf_scale_method, conf_border_color,
        input  conf_valid,
        output conf_ready, frame_finished, underrun
    );

endinterface

// File: rtl/dc_mcl_cfg_shadow_regs.sv
// ---------------------------------------------------------------------------
// dc_mcl_cfg_shadow_regs
// Host-writable shadow configuration, address decode and commit-pending flag.
//   clk, nrst      clock, asynchronous active-low reset
//   en             global enable; nothing changes while low
//   cfg_wr_en/addr/data  shadow write port, data truncated to field width
//   cfg_commit     request a shadow->active swap
//   swap           scheduler is copying the shadow this cycle; clears pending
//   shadow         current shadow set
//   cfg_pending    commit requested, swap not yet done
//   sticky_clr     combinational: enabled write to the sticky-clear address
// ---------------------------------------------------------------------------
module dc_mcl_cfg_shadow_regs
    import dc_mcl_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              cfg_wr_en,
    input  logic [3:0]        cfg_wr_addr,
    input  logic [31:0]       cfg_wr_data,
    input  logic              cfg_commit,
    input  logic              swap,
    output dc_mcl_frame_cfg_t shadow,
    output logic              cfg_pending,
    output logic              sticky_clr
);

    // No field is wider than 24 bits; the top byte of write data is dropped.
    logic unused_wr_data_hi;
    assign unused_wr_data_hi = ^cfg_wr_data[31:24];

    assign sticky_clr = en && cfg_wr_en && (cfg_wr_addr == CFG_ADDR_CLR_STICKY);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow <= '0;
        end else if (en && cfg_wr_en) begin
            case (cfg_wr_addr)
                CFG_ADDR_OFF_X:  shadow.off_x  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_OFF_Y:  shadow.off_y  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_IMG_W:  shadow.img_w  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_IMG_H:  shadow.img_h  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_SCR_W:  shadow.scr_w  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_SCR_H:  shadow.scr_h  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_TEX_W:  shadow.tex_w  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_TEX_H:  shadow.tex_h  <= cfg_wr_data[SCR_SIZE_WIDTH-1:0];
                CFG_ADDR_SCALE:  shadow.scale  <= cfg_wr_data[SCALE_METHOD_WIDTH-1:0];
                CFG_ADDR_BORDER: shadow.border <= cfg_wr_data[RGB_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // A swap consumes the pending request; a commit landing on the swap
    // cycle is a repeat of an already-pending commit and is dropped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_pending <= 1'b0;
        end else if (en) begin
            if (swap) begin
                cfg_pending <= 1'b0;
            end else if (cfg_commit) begin
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dc_mcl_frame_scheduler.sv
// ---------------------------------------------------------------------------
// dc_mcl_frame_scheduler
// Frame-level scheduler in front of the lines display manager (LDM).
// Swaps the shadow configuration into the active set only at vertical
// blanking start, launches one LDM frame per vblank, counts completed frames
// and records underruns.
// Ports:
//   clk, nrst                    clock, asynchronous active-low reset
//   en                           global enable, all state holds while low
//   cfg_wr_en/addr/data          shadow register write port
//   cfg_commit, cfg_pending      commit request / request outstanding
//   vertical_blanking            rising edge marks frame start
//   ldm                          master modport: conf_*, conf_valid,
//                                conf_ready, frame_finished, underrun
//   frame_cnt                    completed frames, wraps
//   underrun_sticky              set on underrun, cleared by write to addr 15
//   underrun_cnt                 saturating underrun count (optional)
//   state_dbg                    current FSM state
// Build option: define DC_MCL_UNDERRUN_CNT_EN to add underrun_cnt.
// ---------------------------------------------------------------------------
module dc_mcl_frame_scheduler
    import dc_mcl_pkg::*;
#(
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic                       cfg_wr_en,
    input  logic [3:0]                 cfg_wr_addr,
    input  logic [31:0]                cfg_wr_data,
    input  logic                       cfg_commit,
    output logic                       cfg_pending,
    input  logic                       vertical_blanking,
    dc_mcl_frame_scheduler_if.master   ldm,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       underrun_sticky,
`ifdef DC_MCL_UNDERRUN_CNT_EN
    output logic [7:0]                 underrun_cnt,
`endif
    output logic [2:0]                 state_dbg
);

    frame_state_t      state;
    dc_mcl_frame_cfg_t shadow;
    dc_mcl_frame_cfg_t active;
    logic              vertical_blanking_r;
    logic              vb_rise;
    logic              swap;
    logic              sticky_clr;
    logic              conf_valid_r;

    assign vb_rise = vertical_blanking && !vertical_blanking_r;
    // The shadow is copied only on the edge that leaves ARM for a launch.
    assign swap    = en && (state == ARM) && vb_rise && cfg_pending;

    dc_mcl_cfg_shadow_regs u_shadow (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .cfg_commit  (cfg_commit),
        .swap        (swap),
        .shadow      (shadow),
        .cfg_pending (cfg_pending),
        .sticky_clr  (sticky_clr)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vertical_blanking_r <= 1'b0;
        end else if (en) begin
            vertical_blanking_r <= vertical_blanking;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= UNCONF;
            active       <= '0;
            conf_valid_r <= 1'b0;
            frame_cnt    <= '0;
        end else if (en) begin
            case (state)
                UNCONF: begin
                    if (cfg_pending) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (vb_rise) begin
                        state        <= ISSUE;
                        conf_valid_r <= 1'b1;
                        if (cfg_pending) begin
                            active <= shadow;
                        end
                    end
                end
                ISSUE: begin
                    if (conf_valid_r && ldm.conf_ready) begin
                        state        <= ACTIVE;
                        conf_valid_r <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Underrun takes priority: the frame is not counted.
                    if (ldm.underrun) begin
                        state <= RECOVER;
                    end else if (ldm.frame_finished) begin
                        state     <= ARM;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    state <= ARM;
                end
                default: begin
                    state        <= UNCONF;
                    conf_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Set wins over clear so an underrun is never lost to a host clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            underrun_sticky <= 1'b0;
        end else if (en) begin
            if (ldm.underrun) begin
                underrun_sticky <= 1'b1;
            end else if (sticky_clr) begin
                underrun_sticky <= 1'b0;
            end
        end
    end

`ifdef DC_MCL_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            underrun_cnt <= 8'd0;
        end else if (en) begin
            if (sticky_clr) begin
                underrun_cnt <= ldm.underrun ? 8'd1 : 8'd0;
            end else if (ldm.underrun && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end
`endif

    assign state_dbg = state;

    assign ldm.conf_valid          = conf_valid_r;
    assign ldm.conf_image_offset_x = active.off_x;
    assign ldm.conf_image_offset_y = active.off_y;
    assign ldm.conf_image_width    = active.img_w;
    assign ldm.conf_image_height   = active.img_h;
    assign ldm.conf_screen_width   = active.scr_w;
    assign ldm.conf_screen_height  = active.scr_h;
    assign ldm.conf_tex_width      = active.tex_w;
    assign ldm.conf_tex_height     = active.tex_h;
    assign ldm.conf_scale_method   = active.scale;
    assign ldm.conf_border_color   = active.border;

endmodule

// File: tb/tb_dc_mcl_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dc_mcl_frame_scheduler
// Directed sequences, a table of shadow writes, and a randomized run checked
// against a behavioural model of the scheduler.
// ---------------------------------------------------------------------------
module tb_dc_mcl_frame_scheduler;
    import dc_mcl_pkg::*;

    localparam int FCW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic           en = 1'b1;
    logic           cfg_wr_en = 1'b0;
    logic [3:0]     cfg_wr_addr = 4'd0;
    logic [31:0]    cfg_wr_data = 32'd0;
    logic           cfg_commit = 1'b0;
    logic           cfg_pending;
    logic           vertical_blanking = 1'b0;
    logic [FCW-1:0] frame_cnt;
    logic           underrun_sticky;
    logic [2:0]     state_dbg;
`ifdef DC_MCL_UNDERRUN_CNT_EN
    logic [7:0]     underrun_cnt;
`endif

    dc_mcl_frame_scheduler_if ldm_if();

    dc_mcl_frame_scheduler #(.FRAME_CNT_WIDTH(FCW)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .en                (en),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_addr       (cfg_wr_addr),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_commit        (cfg_commit),
        .cfg_pending       (cfg_pending),
        .vertical_blanking (vertical_blanking),
        .ldm               (ldm_if),
        .frame_cnt         (frame_cnt),
        .underrun_sticky   (underrun_sticky),
`ifdef DC_MCL_UNDERRUN_CNT_EN
        .underrun_cnt      (underrun_cnt),
`endif
        .state_dbg         (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_field(input int i);
        case (i)
            0: return 32'(ldm_if.conf_image_offset_x);
            1: return 32'(ldm_if.conf_image_offset_y);
            2: return 32'(ldm_if.conf_image_width);
            3: return 32'(ldm_if.conf_image_height);
            4: return 32'(ldm_if.conf_screen_width);
            5: return 32'(ldm_if.conf_screen_height);
            6: return 32'(ldm_if.conf_tex_width);
            7: return 32'(ldm_if.conf_tex_height);
            8: return 32'(ldm_if.conf_scale_method);
            default: return 32'(ldm_if.conf_border_color);
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input int i);
        if (i < 8) return 32'h0000_0FFF;
        if (i == 8) return 32'h0000_0003;
        return 32'h00FF_FFFF;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        cyc();
        cfg_wr_en = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
    endtask

    // Starting from the waiting-for-vblank state: vblank edge, handshake,
    // frame end. The frame count is expected to advance by one.
    task automatic run_frame();
        vertical_blanking = 1'b0; cyc();
        vertical_blanking = 1'b1; cyc();
        chk("frame_launch_valid", 32'(ldm_if.conf_valid), 32'd1);
        ldm_if.conf_ready = 1'b1; cyc(); ldm_if.conf_ready = 1'b0;
        chk("frame_accept_valid", 32'(ldm_if.conf_valid), 32'd0);
        ldm_if.frame_finished = 1'b1; cyc(); ldm_if.frame_finished = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << FCW);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    // ---------------- behavioural model ----------------
    // Phases of a frame as seen from the host side.
    localparam int P_NO_CFG = 0, P_WAIT_VB = 1, P_LAUNCH = 2, P_IN_FRAME = 3, P_COOLDOWN = 4;
    logic [31:0] m_shadow [10];
    logic [31:0] m_active [10];
    int   m_phase;
    bit   m_pend, m_valid, m_sticky, m_vb_prev;
    int   m_cnt, m_ucnt;

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_shadow[i] = '0; m_active[i] = '0;
        end
        m_phase = P_NO_CFG; m_pend = 0; m_valid = 0; m_sticky = 0;
        m_vb_prev = 0; m_cnt = 0; m_ucnt = 0;
    endtask

    task automatic model_step();
        bit rise, swapped, clr;
        if (!en) return;
        rise = vertical_blanking && !m_vb_prev;
        m_vb_prev = vertical_blanking;
        swapped = 0;
        if (m_phase == P_NO_CFG) begin
            if (m_pend) m_phase = P_WAIT_VB;
        end else if (m_phase == P_WAIT_VB) begin
            if (rise) begin
                m_phase = P_LAUNCH; m_valid = 1;
                if (m_pend) begin
                    m_active = m_shadow; swapped = 1;
                end
            end
        end else if (m_phase == P_LAUNCH) begin
            if (ldm_if.conf_ready) begin
                m_phase = P_IN_FRAME; m_valid = 0;
            end
        end else if (m_phase == P_IN_FRAME) begin
            if (ldm_if.underrun) m_phase = P_COOLDOWN;
            else if (ldm_if.frame_finished) begin
                m_phase = P_WAIT_VB; m_cnt = (m_cnt + 1) % (1 << FCW);
            end
        end else begin
            m_phase = P_WAIT_VB;
        end
        clr = cfg_wr_en && (cfg_wr_addr == 4'd15);
        if (ldm_if.underrun) m_sticky = 1;
        else if (clr) m_sticky = 0;
        if (clr) m_ucnt = ldm_if.underrun ? 1 : 0;
        else if (ldm_if.underrun && m_ucnt < 255) m_ucnt++;
        if (swapped) m_pend = 0;
        else if (cfg_commit) m_pend = 1;
        if (cfg_wr_en && cfg_wr_addr < 4'd10)
            m_shadow[cfg_wr_addr] = cfg_wr_data & field_mask(int'(cfg_wr_addr));
    endtask

    // ---------------- write table ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          fidx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    initial begin
        vecs[0]  = '{4'd0,  32'hFFFF_F123, 0, 32'h123};
        vecs[1]  = '{4'd1,  32'd77,        1, 32'd77};
        vecs[2]  = '{4'd2,  32'd1920,      2, 32'd1920};
        vecs[3]  = '{4'd3,  32'd1080,      3, 32'd1080};
        vecs[4]  = '{4'd4,  32'd800,       4, 32'd800};
        vecs[5]  = '{4'd5,  32'd4095,      5, 32'd4095};
        vecs[6]  = '{4'd6,  32'd256,       6, 32'd256};
        vecs[7]  = '{4'd7,  32'h000A_BCDE, 7, 32'hCDE};
        vecs[8]  = '{4'd8,  32'h7,         8, 32'h3};
        vecs[9]  = '{4'd9,  32'hFF12_3456, 9, 32'h12_3456};
        vecs[10] = '{4'd12, 32'h555,       0, 32'h123};

        ldm_if.conf_ready = 1'b0;
        ldm_if.frame_finished = 1'b0;
        ldm_if.underrun = 1'b0;

        // reset state
        #1;
        chk("rst_valid", 32'(ldm_if.conf_valid), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_sticky", 32'(underrun_sticky), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(UNCONF));
        repeat (2) cyc();
        nrst = 1'b1;
        cyc();

        // first launch
        wr(4'd5, 32'd480);
        commit();
        chk("t1_pending_set", 32'(cfg_pending), 32'd1);
        cyc();
        chk("t1_state_arm", 32'(state_dbg), 32'(ARM));
        vertical_blanking = 1'b1;
        chk("t1_valid_before", 32'(ldm_if.conf_valid), 32'd0);
        cyc();
        chk("t1_valid", 32'(ldm_if.conf_valid), 32'd1);
        chk("t1_scr_h", dut_field(5), 32'd480);
        chk("t1_pending_clr", 32'(cfg_pending), 32'd0);

        // stalled handshake
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_valid_hold", 32'(ldm_if.conf_valid), 32'd1);
            chk("t2_scr_h_hold", dut_field(5), 32'd480);
        end
        ldm_if.conf_ready = 1'b1; cyc(); ldm_if.conf_ready = 1'b0;
        chk("t2_valid_drop", 32'(ldm_if.conf_valid), 32'd0);
        chk("t2_state_active", 32'(state_dbg), 32'(ACTIVE));

        // commit mid-frame waits for the next vblank
        wr(4'd2, 32'd640);
        commit();
        chk("t3_pending", 32'(cfg_pending), 32'd1);
        chk("t3_img_w_old", dut_field(2), 32'd0);
        ldm_if.frame_finished = 1'b1; cyc(); ldm_if.frame_finished = 1'b0;
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t3_img_w_still_old", dut_field(2), 32'd0);
        vertical_blanking = 1'b0; cyc();
        chk("t3_img_w_pre_vb", dut_field(2), 32'd0);
        vertical_blanking = 1'b1; cyc();
        chk("t3_img_w_new", dut_field(2), 32'd640);
        chk("t3_pending_clr", 32'(cfg_pending), 32'd0);
        ldm_if.conf_ready = 1'b1; cyc(); ldm_if.conf_ready = 1'b0;

        // underrun and frame_finished together
        ldm_if.underrun = 1'b1; ldm_if.frame_finished = 1'b1; cyc();
        ldm_if.underrun = 1'b0; ldm_if.frame_finished = 1'b0;
        chk("t4_sticky", 32'(underrun_sticky), 32'd1);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t4_state_recover", 32'(state_dbg), 32'(RECOVER));
        cyc();
        chk("t4_state_arm", 32'(state_dbg), 32'(ARM));
        vertical_blanking = 1'b0; cyc();
        vertical_blanking = 1'b1; cyc();
        chk("t4_relaunch", 32'(ldm_if.conf_valid), 32'd1);
        ldm_if.conf_ready = 1'b1; cyc(); ldm_if.conf_ready = 1'b0;
        ldm_if.frame_finished = 1'b1; cyc(); ldm_if.frame_finished = 1'b0;
        exp_cnt = 2;
        chk("t4_frame_cnt2", 32'(frame_cnt), 32'd2);

        // enable low across a vblank edge
        vertical_blanking = 1'b0; cyc();
        en = 1'b0; vertical_blanking = 1'b1; cfg_commit = 1'b1;
        ldm_if.frame_finished = 1'b1; ldm_if.underrun = 1'b1;
        repeat (3) cyc();
        chk("t5_no_launch", 32'(ldm_if.conf_valid), 32'd0);
        chk("t5_pending", 32'(cfg_pending), 32'd0);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("t5_sticky", 32'(underrun_sticky), 32'd1);
        chk("t5_state", 32'(state_dbg), 32'(ARM));
        cfg_commit = 1'b0; ldm_if.frame_finished = 1'b0; ldm_if.underrun = 1'b0;
        en = 1'b1; cyc();
        chk("t5_held_edge_launch", 32'(ldm_if.conf_valid), 32'd1);
        ldm_if.conf_ready = 1'b1; cyc(); ldm_if.conf_ready = 1'b0;
        wr(4'd15, 32'd0);
        chk("t5_sticky_clr", 32'(underrun_sticky), 32'd0);
        ldm_if.frame_finished = 1'b1; cyc(); ldm_if.frame_finished = 1'b0;
        exp_cnt = 3;

        // write table: write, commit, one frame, check the active field
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            commit();
            run_frame();
            chk($sformatf("tbl%0d_field%0d", i, vecs[i].fidx), dut_field(vecs[i].fidx), vecs[i].exp);
        end

        // frame counter wrap
        while (exp_cnt != 0) run_frame();

        // asynchronous reset mid-frame
        vertical_blanking = 1'b0; cyc();
        vertical_blanking = 1'b1; cyc();
        #3 nrst = 1'b0;
        #1;
        chk("arst_valid", 32'(ldm_if.conf_valid), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'(UNCONF));
        chk("arst_scr_h", dut_field(5), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        vertical_blanking = 1'b0;
        cyc();
        nrst = 1'b1;
        cyc();

`ifdef DC_MCL_UNDERRUN_CNT_EN
        for (int i = 0; i < 256; i++) begin
            ldm_if.underrun = 1'b1; cyc(); ldm_if.underrun = 1'b0; cyc();
        end
        chk("ucnt_sat", 32'(underrun_cnt), 32'd255);
        wr(4'd15, 32'd0);
        chk("ucnt_clr", 32'(underrun_cnt), 32'd0);
        chk("ucnt_sticky_clr", 32'(underrun_sticky), 32'd0);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd15; ldm_if.underrun = 1'b1; cyc();
        cfg_wr_en = 1'b0; ldm_if.underrun = 1'b0;
        chk("ucnt_clr_and_ur", 32'(underrun_cnt), 32'd1);
        chk("ucnt_sticky_ur", 32'(underrun_sticky), 32'd1);
`endif

        // randomized run against the model
        nrst = 1'b0; cyc(); nrst = 1'b1;
        model_reset();
        vertical_blanking = 1'b0;
        cyc();
        for (int n = 0; n < 3000; n++) begin
            en                    = ($urandom_range(0, 9) != 0);
            cfg_wr_en             = ($urandom_range(0, 3) == 0);
            cfg_wr_addr           = 4'($urandom_range(0, 15));
            cfg_wr_data           = $urandom;
            cfg_commit            = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) vertical_blanking = ~vertical_blanking;
            ldm_if.conf_ready     = ($urandom_range(0, 2) != 0);
            ldm_if.frame_finished = ($urandom_range(0, 7) == 0);
            ldm_if.underrun       = ($urandom_range(0, 39) == 0);
            model_step();
            cyc();
            chk("rnd_valid", 32'(ldm_if.conf_valid), 32'(m_valid));
            chk("rnd_pending", 32'(cfg_pending), 32'(m_pend));
            chk("rnd_frame_cnt", 32'(frame_cnt), 32'(m_cnt));
            chk("rnd_sticky", 32'(underrun_sticky), 32'(m_sticky));
`ifdef DC_MCL_UNDERRUN_CNT_EN
            chk("rnd_ucnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
            for (int f = 0; f < 10; f++)
                chk($sformatf("rnd_field%0d", f), dut_field(f), m_active[f]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
